// File: rtl/f_bist.sv
// Built-in self-test sequencer for the 3-input function f: walks all eight input
// vectors, waits a settle window on each, samples f and scores it against a golden table.
module f_bist #(
   parameter int         SETTLE_CYCLES = 1,
   parameter logic [7:0] EXPECTED      = 8'b0111_0000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       dut_s,
   output logic       vec_a,
   output logic       vec_b,
   output logic       vec_c,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic       err_valid,
   output logic [2:0] first_err_idx,
   output logic [1:0] o_dbg_state
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   // The sample cycle itself counts as one held cycle, so the counter covers N-1..0.
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   logic [1:0] r_state;
   logic [2:0] r_idx;
   logic [3:0] r_cnt;
   logic       r_pass;
   logic [3:0] r_err_count;
   logic       r_err_valid;
   logic [2:0] r_first_err;

   logic       w_accept;
   logic       w_mismatch;
   logic [3:0] w_err_count_nxt;

   // A start is only honoured when no run is in flight (IDLE or the DONE cycle).
   assign w_accept        = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_mismatch      = (r_state == S_SAMPLE) && (dut_s != EXPECTED[r_idx]);
   assign w_err_count_nxt = r_err_count + {3'd0, w_mismatch};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_idx       <= 3'd0;
         r_cnt       <= 4'd0;
         r_pass      <= 1'b0;
         r_err_count <= 4'd0;
         r_err_valid <= 1'b0;
         r_first_err <= 3'd0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_accept) begin
                  r_state     <= S_SETTLE;
                  r_idx       <= 3'd0;
                  r_cnt       <= SETTLE_LOAD;
                  r_pass      <= 1'b0;
                  r_err_count <= 4'd0;
                  r_err_valid <= 1'b0;
                  r_first_err <= 3'd0;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_SETTLE: begin
               if (r_cnt == 4'd0) begin
                  r_state <= S_SAMPLE;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_SAMPLE: begin
               r_err_count <= w_err_count_nxt;
               if (w_mismatch && !r_err_valid) begin
                  r_err_valid <= 1'b1;
                  r_first_err <= r_idx;
               end
               // Verdict must include this final sample, hence the next-count term.
               if (r_idx == 3'd7) begin
                  r_state <= S_DONE;
                  r_pass  <= (w_err_count_nxt == 4'd0);
               end else begin
                  r_state <= S_SETTLE;
                  r_idx   <= r_idx + 3'd1;
                  r_cnt   <= SETTLE_LOAD;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign {vec_a, vec_b, vec_c} = r_idx;
   assign busy          = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
   assign done          = (r_state == S_DONE);
   assign pass          = r_pass;
   assign err_count     = r_err_count;
   assign err_valid     = r_err_valid;
   assign first_err_idx = r_first_err;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_f_bist.sv
// Directed bench for f_bist: two instances (N=1 and N=3) drive a bench model of f
// that can be switched between correct, stuck-at-0 and inverted behaviour.
module tb_f_bist;

   logic       clk;
   logic       rst_n;

   logic       start1, dut_s1, va1, vb1, vc1, busy1, done1, pass1, ev1;
   logic [3:0] ec1;
   logic [2:0] fe1;
   logic [1:0] st1;

   logic       start3, dut_s3, va3, vb3, vc3, busy3, done3, pass3, ev3;
   logic [3:0] ec3;
   logic [2:0] fe3;
   logic [1:0] st3;

   int mode1;
   int err_cnt;
   int chk_cnt;

   f_bist #(.SETTLE_CYCLES(1), .EXPECTED(8'b0111_0000)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .dut_s(dut_s1),
      .vec_a(va1), .vec_b(vb1), .vec_c(vc1), .busy(busy1), .done(done1),
      .pass(pass1), .err_count(ec1), .err_valid(ev1), .first_err_idx(fe1),
      .o_dbg_state(st1)
   );

   f_bist #(.SETTLE_CYCLES(3), .EXPECTED(8'b0111_0000)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .dut_s(dut_s3),
      .vec_a(va3), .vec_b(vb3), .vec_c(vc3), .busy(busy3), .done(done3),
      .pass(pass3), .err_count(ec3), .err_valid(ev3), .first_err_idx(fe3),
      .o_dbg_state(st3)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic f_fn(input logic a, input logic b, input logic c);
      return (a & ~c) | (a & ~b & c);
   endfunction

   // mode: 0 correct f, 1 stuck-at-0, 2 inverted f
   function automatic logic f_variant(input int mode, input logic a, input logic b, input logic c);
      if (mode == 1) return 1'b0;
      if (mode == 2) return ~f_fn(a, b, c);
      return f_fn(a, b, c);
   endfunction

   function automatic bit mism(input int mode, input int k);
      logic [2:0] v;
      v = 3'(k);
      return f_variant(mode, v[2], v[1], v[0]) != f_fn(v[2], v[1], v[0]);
   endfunction

   always_comb dut_s1 = f_variant(mode1, va1, vb1, vc1);
   always_comb dut_s3 = f_fn(va3, vb3, vc3);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single start pulse on the N=1 instance, checking the whole timeline.
   task automatic run_n1(input int mode, input int exp_err, input int exp_first, input bit exp_pass);
      int cnt;
      int k;
      int exp_vec;
      mode1  = mode;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      check($sformatf("m%0d busy_e0", mode), busy1, 1);
      check($sformatf("m%0d vec_e0", mode), {va1, vb1, vc1}, 0);
      cnt = 0;
      for (int e = 1; e <= 16; e++) begin
         tick();
         if (e % 2 == 0) begin
            k = e / 2 - 1;
            if (mism(mode, k)) cnt++;
         end
         exp_vec = (e < 16) ? e / 2 : 7;
         check($sformatf("m%0d vec_e%0d", mode, e), {va1, vb1, vc1}, exp_vec);
         check($sformatf("m%0d errcnt_e%0d", mode, e), ec1, cnt);
         check($sformatf("m%0d done_e%0d", mode, e), done1, (e == 16) ? 1 : 0);
         check($sformatf("m%0d busy_e%0d", mode, e), busy1, (e < 16) ? 1 : 0);
      end
      check($sformatf("m%0d err_final", mode), ec1, exp_err);
      check($sformatf("m%0d pass", mode), pass1, exp_pass);
      check($sformatf("m%0d err_valid", mode), ev1, (exp_err != 0) ? 1 : 0);
      if (exp_err != 0) check($sformatf("m%0d first_err", mode), fe1, exp_first);
      tick();
      check($sformatf("m%0d done_e17", mode), done1, 0);
      check($sformatf("m%0d busy_e17", mode), busy1, 0);
      check($sformatf("m%0d pass_hold", mode), pass1, exp_pass);
      check($sformatf("m%0d err_hold", mode), ec1, exp_err);
      check($sformatf("m%0d vec_hold", mode), {va1, vb1, vc1}, 7);
   endtask

   initial begin
      err_cnt = 0;
      chk_cnt = 0;
      mode1   = 0;
      start1  = 1'b0;
      start3  = 1'b0;
      rst_n   = 1'b0;
      repeat (3) tick();
      check("rst busy", busy1, 0);
      check("rst done", done1, 0);
      check("rst pass", pass1, 0);
      check("rst errcnt", ec1, 0);
      check("rst errvalid", ev1, 0);
      check("rst first", fe1, 0);
      check("rst vec", {va1, vb1, vc1}, 0);
      check("rst busy3", busy3, 0);
      rst_n = 1'b1;
      tick();

      // correct f, stuck-at-0 (vectors 4,5,6 fail), inverted f (all fail)
      run_n1(0, 0, 0, 1'b1);
      run_n1(1, 3, 4, 1'b0);
      run_n1(2, 8, 0, 1'b0);

      // N=3 with start pulses while busy, which must not restart the run
      start3 = 1'b1;
      tick();
      start3 = 1'b0;
      for (int e = 1; e <= 32; e++) begin
         start3 = (e == 5 || e == 13 || e == 30) ? 1'b1 : 1'b0;
         tick();
         check($sformatf("n3 vec_e%0d", e), {va3, vb3, vc3}, (e < 32) ? e / 4 : 7);
         check($sformatf("n3 done_e%0d", e), done3, (e == 32) ? 1 : 0);
      end
      start3 = 1'b0;
      check("n3 pass", pass3, 1);
      check("n3 errcnt", ec3, 0);
      check("n3 errvalid", ev3, 0);
      tick();
      check("n3 done_e33", done3, 0);

      // reset while vector 3 is being driven; inverted f so counts are nonzero first
      mode1  = 2;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      repeat (7) tick();
      check("mid vec", {va1, vb1, vc1}, 3);
      check("mid errcnt", ec1, 3);
      #2 rst_n = 1'b0;
      #1;
      check("arst busy", busy1, 0);
      check("arst vec", {va1, vb1, vc1}, 0);
      check("arst errcnt", ec1, 0);
      check("arst errvalid", ev1, 0);
      repeat (3) begin
         tick();
         check("arst done", done1, 0);
      end
      #2 rst_n = 1'b1;
      tick();
      run_n1(0, 0, 0, 1'b1);

      // start held high: inverted f first run, correct f afterwards; period 17 cycles
      mode1  = 2;
      start1 = 1'b1;
      tick();
      for (int e = 1; e <= 34; e++) begin
         if (e == 17) mode1 = 0;
         tick();
         check($sformatf("held done_e%0d", e), done1, (e == 16 || e == 33) ? 1 : 0);
         if (e == 16) begin
            check("held errcnt_r1", ec1, 8);
            check("held pass_r1", pass1, 0);
         end
         if (e == 17) begin
            check("held busy_r2", busy1, 1);
            check("held clr_errcnt", ec1, 0);
            check("held clr_pass", pass1, 0);
            check("held clr_errvalid", ev1, 0);
            check("held vec_r2", {va1, vb1, vc1}, 0);
         end
         if (e == 33) begin
            check("held errcnt_r2", ec1, 0);
            check("held pass_r2", pass1, 1);
         end
         if (e == 34) check("held busy_r3", busy1, 1);
      end
      start1 = 1'b0;
      repeat (20) tick();
      check("held idle", busy1, 0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/f_bist.md
# f_bist

Self-test engine for the 3-input combinational function f (s = a·¬c + a·¬b·c). On a start request it sequences through all eight input combinations, holds each vector stable for a settle window, and samples the function output. It compares each sample against a golden truth table and reports the pass/fail result and the error count. It sits beside f in the design: its vector outputs drive f's inputs, and f's output feeds back into it.

## Interface
- SETTLE_CYCLES, 1: cycles each vector is held before sampling; legal range 1..15.
- EXPECTED, 8'b0111_0000: golden truth table; bit i is the expected s for vector {a,b,c} = i.

- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  run request; sampled on rising clk edges.
- dut_s  input  1  output of f under test.
- vec_a, vec_b, vec_c  output  1 each  drive f inputs a, b, c.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  1 if the last completed run had zero mismatches; held until the next run starts.
- err_count  output  4  mismatches in the current or last run (0..8).
- err_valid  output  1  at least one mismatch recorded in the current or last run.
- first_err_idx  output  3  vector index of the first mismatch; valid when err_valid=1.

## Operation
- The block is a registered FSM with states IDLE, SETTLE, SAMPLE and DONE.
- It uses a 3-bit vector index idx and a 4-bit settle counter.
- {vec_a, vec_b, vec_c} = idx at all times; vec_a is the MSB.
- IDLE: when start=1 the block clears err_count, err_valid, first_err_idx and pass, sets idx=0, loads the counter with SETTLE_CYCLES-1, asserts busy and goes to SETTLE. When start=0 it stays in IDLE.
- SETTLE: the counter decrements each cycle. When the counter reaches 0 the block goes to SAMPLE.
- SAMPLE: the block compares dut_s with EXPECTED[idx].
  - On a mismatch, err_count increments. If err_valid=0, the block also sets err_valid=1 and first_err_idx=idx.
  - If idx=7 the block goes to DONE.
  - Otherwise it increments idx, reloads the counter and goes to SETTLE.
- DONE: done=1 and busy=0 for this one cycle. pass = (err_count==0), computed including the final sample.
  - From DONE the block goes to IDLE.
  - If start=1 in the DONE cycle, that start is accepted: the block restarts directly as described for IDLE.
- start while busy=1 (SETTLE or SAMPLE) is ignored and has no effect.
- err_count saturates arithmetically at 8 because there are only 8 samples; a 4-bit width is sufficient and no wrap occurs.
- Reset (rst_n=0, asynchronous, also mid-run) forces immediately:
  - state=IDLE, idx=0, vec_a/b/c=0
  - busy=0, done=0, pass=0
  - err_count=0, err_valid=0, first_err_idx=0
- After reset is released, the first start performs a full 8-vector run.

## Timing
- Let N=SETTLE_CYCLES. Edge 0 is the rising edge at which start=1 is sampled in IDLE or DONE.
- After edge 0: busy=1 and the vector outputs are 000.
- Vector k is driven from edge k(N+1) to edge (k+1)(N+1).
- dut_s for vector k is sampled at edge (k+1)(N+1). The DUT therefore sees each vector for N+1 full cycles before sampling.
- err_count, err_valid and first_err_idx update at that same sampling edge.
- After edge 8(N+1): done=1, busy=0 and pass is valid.
- After edge 8(N+1)+1: done=0. pass, err_count, err_valid and first_err_idx hold until the next accepted start.
- Run latency is 8(N+1) cycles from start to done. The default (N=1) gives done after edge 16.
- The vector outputs hold 111 after the run until the next start or reset.
- Back-to-back runs: a start held high continuously produces one run every 8(N+1)+1 cycles.

## Test plan
- Correct f connected, N=1, start pulsed at edge 0 -> vectors step 000..111 every 2 cycles; done pulses after edge 16; pass=1, err_count=0, err_valid=0.
- dut_s tied 0 -> mismatches at idx 4, 5, 6; err_count=3, first_err_idx=4, pass=0.
- dut_s = ¬f -> err_count=8, first_err_idx=0, pass=0.
- N=3, correct f -> done after edge 32; each vector held 4 cycles; start pulses while busy=1 cause no restart and no change to the counts.
- rst_n pulled low while idx=3 -> all outputs 0 immediately, with no done pulse. After release, a start gives a full run with done after edge 16 and correct results.
- start held high continuously, correct f -> done pulses every 17 cycles. err_count is cleared at each restart and pass=1 at each done.
